// File: rtl/div_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : div_seq_ctrl
//  Purpose  : Multi-cycle sequencer for DIV/DIVU. A WIDTH-iteration restoring
//             divider with a control FSM (IDLE -> CALC -> FIX -> IDLE),
//             operand latches and HI/LO result registers. The pipeline stalls
//             while busy is high and samples lo/hi after the done pulse.
//
//  Ports    : clk          system clock, all state changes on rising edge
//             rst          synchronous active-high reset (highest priority)
//             start        divide request, only accepted in IDLE
//             is_unsigned  1 = DIVU, 0 = DIV (two's complement)
//             a, b         dividend / divisor, latched on accepted start
//             cancel       abort an in-flight divide (pipeline flush)
//             busy         high while a divide is in flight
//             done         one-cycle pulse when lo/hi are updated
//             lo, hi       quotient / remainder registers
//
//  Config   : DIV_ZERO_FAST_EN - when defined, a zero divisor skips CALC and
//             the divide-by-zero result is committed one edge after start.
//             Results are identical with or without it; only latency changes.
//
//  Revision : 1.0 - initial release
// ============================================================================
module div_seq_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_unsigned,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi
);

  localparam int             CW   = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;

  logic [CW-1:0]    count;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quot;
  logic [WIDTH-1:0] dvsr;
  logic             sign_q;
  logic             sign_r;

  logic             load;
  logic             step;
  logic             commit;

  // --------------------------------------------------------------------------
  // Operand conditioning. The signedness is folded into the two sign flags at
  // start, so is_unsigned itself needs no register afterwards.
  // --------------------------------------------------------------------------
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic             fast_zero;

  assign a_neg = ~is_unsigned & a[WIDTH-1];
  assign b_neg = ~is_unsigned & b[WIDTH-1];
  // Magnitude of the most negative value wraps to itself, which is exactly
  // the unsigned magnitude the divider needs (gives the overflow result).
  assign a_mag = a_neg ? (~a + 1'b1) : a;
  assign b_mag = b_neg ? (~b + 1'b1) : b;

`ifdef DIV_ZERO_FAST_EN
  assign fast_zero = (b == '0);
`else
  assign fast_zero = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // One restoring step: shift {rem,quot} left, trial-subtract the divisor.
  // rem < dvsr keeps the shifted value below 2*dvsr, so the (WIDTH+1)-bit
  // difference is negative exactly when its top bit is set.
  // --------------------------------------------------------------------------
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic             fits;
  logic [WIDTH-1:0] rem_step;
  logic [WIDTH-1:0] quot_step;

  assign shifted   = {rem, quot[WIDTH-1]};
  assign trial     = shifted - {1'b0, dvsr};
  assign fits      = ~trial[WIDTH];
  assign rem_step  = fits ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
  assign quot_step = {quot[WIDTH-2:0], fits};

  // Sign fix-up of the magnitude results.
  logic [WIDTH-1:0] lo_fix;
  logic [WIDTH-1:0] hi_fix;

  assign lo_fix = sign_q ? (~quot + 1'b1) : quot;
  assign hi_fix = sign_r ? (~rem  + 1'b1) : rem;

  // --------------------------------------------------------------------------
  // FSM state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM next-state and control decode
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    busy      = (state != IDLE);
    load      = 1'b0;
    step      = 1'b0;
    commit    = 1'b0;
    unique case (state)
      IDLE: begin
        // cancel is meaningless here; start always wins.
        if (start) begin
          load      = 1'b1;
          state_nxt = fast_zero ? FIX : CALC;
        end
      end
      CALC: begin
        if (cancel) begin
          state_nxt = IDLE;
        end else begin
          step = 1'b1;
          if (count == LAST) begin
            state_nxt = FIX;
          end
        end
      end
      FIX: begin
        state_nxt = IDLE;
        commit    = ~cancel;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath and result registers. lo/hi change only on commit, both at once.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      count  <= '0;
      rem    <= '0;
      quot   <= '0;
      dvsr   <= '0;
      sign_q <= 1'b0;
      sign_r <= 1'b0;
      lo     <= '0;
      hi     <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (load) begin
        count  <= '0;
        // A fast zero-divide preloads what 32 steps would have produced.
        rem    <= fast_zero ? a_mag : '0;
        quot   <= fast_zero ? '1    : a_mag;
        dvsr   <= b_mag;
        sign_q <= a_neg ^ b_neg;
        sign_r <= a_neg;
      end else if (step) begin
        count <= count + CW'(1);
        rem   <= rem_step;
        quot  <= quot_step;
      end
      if (commit) begin
        lo   <= lo_fix;
        hi   <= hi_fix;
        done <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/div_seq_ctrl.md
Name: div_seq_ctrl

Overview:
- Multi-cycle sequencer for the CPU's DIV/DIVU instructions.
- Replaces the single-cycle combinational quotient/remainder path with a 32-iteration restoring divider, plus control FSM, operand latches and HI/LO result registers.
- Sits beside the EX stage. The pipeline controller issues start and holds the pipeline (stalls) while busy=1.
- HI/LO read logic samples lo/hi after done.

Parameters:
- WIDTH, 32, operand/result width. Only 32 is verified. Iteration count equals WIDTH.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request a divide; sampled only in IDLE
- is_unsigned  input  1  1 = DIVU semantics, 0 = DIV (two's-complement); latched with start
- a  input  WIDTH  dividend; latched on accepted start
- b  input  WIDTH  divisor; latched on accepted start
- cancel  input  1  abort in-flight divide (pipeline flush)
- busy  output  1  high while an operation is in flight
- done  output  1  one-cycle pulse when lo/hi update
- lo  output  WIDTH  quotient register
- hi  output  WIDTH  remainder register

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high. When rst=1 at an edge: state=IDLE, busy=0, done=0, lo=0, hi=0, counter=0. This takes priority over everything, including mid-operation.
- States: IDLE, CALC, FIX.
- IDLE:
  - On start=1 at edge E0, latch is_unsigned, |a|, |b|, sign_q=a[31]^b[31] and sign_r=a[31].
  - Signs are forced to 0 when is_unsigned=1; |x|=x when unsigned.
  - Clear the partial remainder, set count=0, go to CALC. busy=1 from E0.
- CALC:
  - Each edge performs one restoring step: shift {rem,quot} left by 1, trial-subtract |b|, set the quotient bit if non-negative, else restore.
  - Edges E1..E32 perform 32 steps. At E32 go to FIX.
- FIX (edge E33):
  - lo = sign_q ? -quot : quot; hi = sign_r ? -rem : rem.
  - done=1 for exactly the cycle after E33, busy=0 after E33, state=IDLE.
- Latency: done visible 33 edges after the start edge. busy is high for 33 cycles.
- a, b and is_unsigned may change freely after E0.
- start while busy=1 is ignored; no queueing.
- start asserted in the same cycle done is high is accepted (back-to-back); done still pulses for the prior result.
- lo/hi hold their value between done pulses and are never partially updated.
- cancel=1 in CALC or FIX: next edge goes to IDLE, busy=0, no done, lo/hi unchanged.
  - cancel in IDLE has no effect.
  - cancel with start in IDLE: start wins.
  - rst overrides cancel.
- Result conventions (match HDL / and %):
  - Quotient truncates toward zero; remainder takes the sign of the dividend.
- Overflow: 0x80000000 / 0xFFFFFFFF signed gives lo=0x80000000, hi=0.
- Divide by zero (b=0), fixed outcome of the algorithm:
  - Unsigned: lo=0xFFFFFFFF, hi=a.
  - Signed, a>=0: lo=0xFFFFFFFF, hi=a.
  - Signed, a<0: lo=0x00000001, hi=a.
  - No exception is raised.

Optional Feature:
- DIV_ZERO_FAST_EN
- Defined:
  - b=0 detected at E0 skips CALC; FIX loads the divide-by-zero results above directly at E1.
  - done is visible after E1; busy is high 1 cycle.
- Undefined: b=0 takes the full 33-edge latency.
- lo/hi values are identical either way.

Test Plan:
- Unsigned: start, a=100, b=7, is_unsigned=1 -> done exactly 33 edges later; lo=14, hi=2; busy high 33 cycles.
- Signed, a=-7 (0xFFFFFFF9), b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). Repeat as unsigned -> lo=0x7FFFFFFC, hi=1.
- Overflow, a=0x80000000, b=0xFFFFFFFF signed -> lo=0x80000000, hi=0.
- Divide by zero, a=0xFFFFFFF0, b=0:
  - Signed -> lo=1, hi=0xFFFFFFF0.
  - Unsigned -> lo=0xFFFFFFFF, hi=0xFFFFFFF0.
  - With DIV_ZERO_FAST_EN, done after 1 edge; otherwise after 33.
- cancel at edge E10 of a divide; lo/hi previously 5/6 -> busy=0 after E10, no done, lo/hi stay 5/6. Extra start pulses during busy are ignored.
- rst asserted mid-CALC -> lo=hi=0, busy=done=0 next cycle. Back-to-back start in the done cycle -> second result correct 33 edges later.
